// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-product scheduler.
package matmul_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, WRITE, DONE} state_t;

  localparam int IDX_W = 4;

  // Accumulator wide enough for WIDTH full-scale products to sum without wrapping.
  function automatic int acc_width(input int bits, input int width);
    return 2 * bits + $clog2(width);
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Result stream of the matrix-product scheduler: one C element per valid/ready handshake.
interface matmul_if
  import matmul_pkg::*;
#(
  parameter int ACC_W = 50
);
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_row;
  logic [IDX_W-1:0] res_col;
  logic [ACC_W-1:0] res_data;

  modport master (output res_valid, res_row, res_col, res_data, input res_ready);
  modport slave  (input res_valid, res_row, res_col, res_data, output res_ready);
endinterface

// File: rtl/mac_lane.sv
// Single multiply-accumulate lane: acc <= a*b + (clear_acc ? 0 : acc) when en.
// One registered stage; no backpressure, the scheduler gates it with en.
module mac_lane #(
  parameter int BITS  = 24,
  parameter int ACC_W = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear_acc,
  input  logic [BITS-1:0]  a,
  input  logic [BITS-1:0]  b,
  output logic [ACC_W-1:0] acc
);

  logic [2*BITS-1:0] prod;

  assign prod = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= ACC_W'(prod) + (clear_acc ? '0 : acc);
    end
  end

endmodule

// File: rtl/matmul_scheduler.sv
// Sequences C=A*B through one MAC lane; first result 2+WIDTH cycles after start, then WIDTH+2 each.
// Only WRITE stalls on res_ready. Optional cycle counter: define MATMUL_CYCLE_CNT_EN.
module matmul_scheduler
  import matmul_pkg::*;
#(
  parameter int BITS  = 24,
  parameter int WIDTH = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [BITS-1:0] a_mat [WIDTH*WIDTH],
  input  logic [BITS-1:0] b_mat [WIDTH*WIDTH],
  output logic            busy,
  output logic            done,
  matmul_if.master        res,
  output logic [15:0]     cycle_cnt
);

  localparam int ACC_W = acc_width(BITS, WIDTH);
  localparam int N     = WIDTH * WIDTH;
  localparam int MI_W  = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [BITS-1:0]  a_reg [N];
  logic [BITS-1:0]  b_reg [N];
  logic [IDX_W-1:0] row, col, k;
  logic [MI_W-1:0]  a_idx, b_idx;
  logic [ACC_W-1:0] lane_acc, res_q;
  logic             lane_en, clear_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (k == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   if (res.res_ready) state_nxt = (row == LAST && col == LAST) ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  assign a_idx     = MI_W'(int'(row) * WIDTH + int'(k));
  assign b_idx     = MI_W'(int'(k) * WIDTH + int'(col));
  assign lane_en   = (state == RUN);
  assign clear_acc = (state == RUN) && (k == '0);

  mac_lane #(.BITS(BITS), .ACC_W(ACC_W)) u_lane (
    .clk       (clk),
    .reset     (reset),
    .en        (lane_en),
    .clear_acc (clear_acc),
    .a         (a_reg[a_idx]),
    .b         (b_reg[b_idx]),
    .acc       (lane_acc)
  );

  // Operands are snapshotted in LOAD so the job is immune to later input changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '{default: '0};
      b_reg <= '{default: '0};
      row   <= '0;
      col   <= '0;
      k     <= '0;
      res_q <= '0;
    end else begin
      case (state)
        LOAD: begin
          a_reg <= a_mat;
          b_reg <= b_mat;
          row   <= '0;
          col   <= '0;
          k     <= '0;
        end
        RUN:   k <= (k == LAST) ? '0 : k + 1'b1;
        DRAIN: res_q <= lane_acc;
        WRITE: if (res.res_ready) begin
          if (col == LAST) begin
            col <= '0;
            row <= (row == LAST) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign res.res_valid = (state == WRITE);
  assign res.res_row   = row;
  assign res.res_col   = col;
  assign res.res_data  = res_q;

`ifdef MATMUL_CYCLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  cnt_q <= '0;
    else if (state == IDLE && state_nxt == LOAD) cnt_q <= '0;
    else if (busy && cnt_q != 16'hFFFF)          cnt_q <= cnt_q + 16'd1;
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler (BITS=24, WIDTH=3).
module tb_matmul_scheduler;
  import matmul_pkg::*;

  localparam int BITS  = 24;
  localparam int N     = 9;
  localparam int ACC_W = 50;
`ifdef MATMUL_CYCLE_CNT_EN
  localparam int CNT_JOB   = 47;
  localparam int CNT_ABORT = 8;
`else
  localparam int CNT_JOB   = 0;
  localparam int CNT_ABORT = 0;
`endif

  logic            clk = 1'b0;
  logic            reset, start, abort;
  logic [BITS-1:0] a_mat [N];
  logic [BITS-1:0] b_mat [N];
  logic            busy, done;
  logic [15:0]     cycle_cnt;

  matmul_if #(.ACC_W(ACC_W)) rif ();

  matmul_scheduler #(.BITS(BITS), .WIDTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .a_mat     (a_mat),
    .b_mat     (b_mat),
    .busy      (busy),
    .done      (done),
    .res       (rif),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  int               vectors = 0;
  int               miscompares = 0;
  logic [ACC_W-1:0] exp_c [N];
  int               q_row [$];
  int               q_col [$];
  logic [ACC_W-1:0] q_dat [$];

  task automatic compute_golden();
    logic [63:0] s;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        s = '0;
        for (int kk = 0; kk < 3; kk++)
          s = s + 64'(a_mat[r*3+kk]) * 64'(b_mat[kk*3+c]);
        exp_c[r*3+c] = s[ACC_W-1:0];
      end
  endtask

  // Pulses start, then records every handshaken result until done (cycle 0 = LOAD).
  task automatic run_job(input int restart_at, output int done_cyc, output int first_cyc);
    q_row.delete(); q_col.delete(); q_dat.delete();
    done_cyc = -1; first_cyc = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      start = (cyc == restart_at);
      if (rif.res_valid && first_cyc < 0) first_cyc = cyc;
      if (rif.res_valid && rif.res_ready) begin
        q_row.push_back(int'(rif.res_row));
        q_col.push_back(int'(rif.res_col));
        q_dat.push_back(rif.res_data);
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; rif.res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin a_mat[i] = '0; b_mat[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if ({busy, done, rif.res_valid} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctrl: busy/done/valid=%b expected 000", {busy, done, rif.res_valid}); end
    vectors++; if ({rif.res_row, rif.res_col} !== 8'h00) begin
      miscompares++; $display("FAIL reset_idx: row/col=%h expected 00", {rif.res_row, rif.res_col}); end
    vectors++; if (rif.res_data !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h expected 0", rif.res_data); end
    vectors++; if (cycle_cnt !== 16'd0) begin
      miscompares++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_identity();
    int dc, fc;
    for (int i = 0; i < N; i++) begin
      a_mat[i] = (i % 4 == 0) ? 24'd1 : 24'd0;
      b_mat[i] = 24'(i + 1);
    end
    run_job(-1, dc, fc);
    vectors++; if (q_dat.size() != N) begin
      miscompares++; $display("FAIL ident_count: got %0d results expected %0d", q_dat.size(), N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++;
      if (q_dat[i] !== ACC_W'(i + 1) || q_row[i] != i / 3 || q_col[i] != i % 3) begin
        miscompares++;
        $display("FAIL ident_elem%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                 i, q_row[i], q_col[i], q_dat[i], i / 3, i % 3, i + 1);
      end
    end
    vectors++; if (fc != 5) begin
      miscompares++; $display("FAIL ident_first_valid: cycle %0d expected 5", fc); end
    // DONE is the 47th cycle after the start edge (LOAD is the first).
    vectors++; if (dc != 46) begin
      miscompares++; $display("FAIL ident_done_time: cycle %0d expected 46", dc); end
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL ident_idle: busy=%b done=%b expected 0 0", busy, done); end
    vectors++; if (cycle_cnt !== 16'(CNT_JOB)) begin
      miscompares++; $display("FAIL ident_cycle_cnt: got %0d expected %0d", cycle_cnt, CNT_JOB); end
  endtask

  task automatic test_full_scale();
    int dc, fc;
    for (int i = 0; i < N; i++) begin a_mat[i] = 24'hFFFFFF; b_mat[i] = 24'hFFFFFF; end
    run_job(-1, dc, fc);
    vectors++; if (q_dat.size() != N) begin
      miscompares++; $display("FAIL full_count: got %0d expected %0d", q_dat.size(), N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++;
      if (q_dat[i] !== 50'h2FFFFFA000003) begin
        miscompares++; $display("FAIL full_elem%0d: got %h expected 2FFFFFA000003", i, q_dat[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] held;
    int stall_left, cyc;
    bit stalled, seen_done;
    for (int i = 0; i < N; i++) begin a_mat[i] = 24'(i + 1); b_mat[i] = 24'(9 - i); end
    compute_golden();
    q_row.delete(); q_col.delete(); q_dat.delete();
    rif.res_ready = 1'b1; stalled = 0; stall_left = 0; seen_done = 0; held = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      if (cyc == 2) for (int i = 0; i < N; i++) begin a_mat[i] = 24'd7; b_mat[i] = 24'd7; end
      if (stall_left > 0) begin
        vectors++;
        if (!rif.res_valid || rif.res_data !== held || rif.res_row !== 4'd1 || rif.res_col !== 4'd2) begin
          miscompares++;
          $display("FAIL bp_hold: valid=%b (%0d,%0d)=%0d expected 1 (1,2)=%0d",
                   rif.res_valid, rif.res_row, rif.res_col, rif.res_data, held);
        end
        stall_left--;
        if (stall_left == 0) rif.res_ready = 1'b1;
      end else if (rif.res_valid && rif.res_row == 4'd1 && rif.res_col == 4'd2 && !stalled) begin
        stalled = 1; rif.res_ready = 1'b0; held = rif.res_data; stall_left = 5;
      end
      if (rif.res_valid && rif.res_ready) begin
        q_row.push_back(int'(rif.res_row));
        q_col.push_back(int'(rif.res_col));
        q_dat.push_back(rif.res_data);
      end
      if (done) seen_done = 1;
    end
    rif.res_ready = 1'b1;
    vectors++; if (!seen_done || cyc - 1 != 51) begin
      miscompares++; $display("FAIL bp_done_time: done=%b cycle %0d expected 51", seen_done, cyc - 1); end
    vectors++; if (q_dat.size() != N) begin
      miscompares++; $display("FAIL bp_count: got %0d expected %0d", q_dat.size(), N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++;
      if (q_dat[i] !== exp_c[i] || q_row[i] != i / 3 || q_col[i] != i % 3) begin
        miscompares++;
        $display("FAIL bp_elem%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                 i, q_row[i], q_col[i], q_dat[i], i / 3, i % 3, exp_c[i]);
      end
    end
  endtask

  task automatic test_abort();
    int dc, fc;
    bit saw_done;
    for (int i = 0; i < N; i++) begin a_mat[i] = 24'(2 * i + 3); b_mat[i] = 24'(100 + i); end
    compute_golden();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    vectors++; if ({busy, rif.res_valid, done} !== 3'b000) begin
      miscompares++; $display("FAIL abort_idle: busy/valid/done=%b expected 000", {busy, rif.res_valid, done}); end
    vectors++; if (cycle_cnt !== 16'(CNT_ABORT)) begin
      miscompares++; $display("FAIL abort_cnt: got %0d expected %0d", cycle_cnt, CNT_ABORT); end
    saw_done = 0;
    repeat (6) begin @(posedge clk); #1; if (done || busy) saw_done = 1; end
    vectors++; if (saw_done) begin
      miscompares++; $display("FAIL abort_quiet: done/busy seen=1 expected 0"); end
    run_job(-1, dc, fc);
    vectors++; if (q_dat.size() != N || dc != 46) begin
      miscompares++; $display("FAIL abort_rerun: %0d results done@%0d expected %0d done@46", q_dat.size(), dc, N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++;
      if (q_dat[i] !== exp_c[i]) begin
        miscompares++; $display("FAIL abort_elem%0d: got %0d expected %0d", i, q_dat[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dc, fc;
    for (int i = 0; i < N; i++) begin a_mat[i] = 24'(i * 1000 + 1); b_mat[i] = 24'(N - i); end
    compute_golden();
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin
      miscompares++; $display("FAIL start_abort_idle: busy=%b expected 0", busy); end
    run_job(10, dc, fc);
    vectors++; if (dc != 46) begin
      miscompares++; $display("FAIL restart_done_time: cycle %0d expected 46", dc); end
    vectors++; if (q_dat.size() != N) begin
      miscompares++; $display("FAIL restart_count: got %0d expected %0d", q_dat.size(), N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++;
      if (q_dat[i] !== exp_c[i]) begin
        miscompares++; $display("FAIL restart_elem%0d: got %0d expected %0d", i, q_dat[i], exp_c[i]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin
      miscompares++; $display("FAIL restart_not_latched: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < N; i++) begin
      a_mat[i] = (i % 4 == 0) ? 24'd1 : 24'd0;
      b_mat[i] = 24'(i + 5);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    vectors++; if (rif.res_data !== 50'd5 || rif.res_col !== 4'd1) begin
      miscompares++; $display("FAIL midrun_pre: col=%0d data=%0d expected col=1 data=5", rif.res_col, rif.res_data); end
    #2 reset = 1'b1;
    #1;
    vectors++; if ({busy, done, rif.res_valid, rif.res_row, rif.res_col} !== 11'd0) begin
      miscompares++; $display("FAIL midrun_async_ctrl: busy/done/valid/row/col=%b expected 0",
                              {busy, done, rif.res_valid, rif.res_row, rif.res_col}); end
    vectors++; if (rif.res_data !== '0 || cycle_cnt !== 16'd0) begin
      miscompares++; $display("FAIL midrun_async_data: data=%0d cnt=%0d expected 0 0", rif.res_data, cycle_cnt); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_full_scale();
    test_backpressure();
    test_abort();
    test_ignored_start();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
